fpu_rr_scheduler: RTL and testbench
===================================

// Module: fpu_rr_scheduler
// PURPOSE
//  Shares one combinational FPU_unit (FP32 add/sub) between NUM_REQ requesters.
//  - Round-robin arbitration; valid/ready handshake per requester.
//  - Operands and result are registered around the FPU.
//  - A single tagged response channel with backpressure.
//  - Sits between the core-side issue logic and the FPU datapath.
// PARAMETERS
//  NUM_REQ   4                   number of requesters (2..8)
//  NUM_OP    1                   passed unchanged to FPU_unit NUM_OP
//  ID_W      $clog2(NUM_REQ)     requester tag width (derived, not overridable)
// PORTS
//  i_clk          in   1            single clock, all logic on rising edge
//  i_rst          in   1            synchronous, active-high reset
//  i_req_valid    in   NUM_REQ      request valid, one bit per requester
//  o_req_ready    out  NUM_REQ      one-hot accept; transfer = valid & ready
//  i_req_add_sub  in   NUM_REQ      per requester: 0 = A+B, 1 = A-B
//  i_req_a        in   NUM_REQ*32   operand A; requester k uses bits [32k+31:32k]
//  i_req_b        in   NUM_REQ*32   operand B, same packing as i_req_a
//  o_rsp_valid    out  1            response valid
//  i_rsp_ready    in   1            response accept
//  o_rsp_id       out  ID_W         index of the requester that issued the op
//  o_rsp_s        out  32           FP32 result
//  o_rsp_ov       out  1            overflow flag from FPU_unit
//  o_rsp_un       out  1            underflow flag from FPU_unit
//  o_busy         out  1            1 when state != IDLE
// BEHAVIOUR
//  - Reset values: FSM=IDLE, rr pointer=0, all outputs 0 (o_req_ready=0,
//    o_rsp_valid=0, o_rsp_*=0).
//  - FSM states:
//    - IDLE: o_req_ready = arbiter grant (one-hot among valid bits, starting
//      at the rr pointer). On transfer: latch op/A/B/id into the operand
//      register, set ptr = id+1 mod NUM_REQ, go to EXEC.
//    - EXEC: FPU_unit evaluates the registered operands. Capture
//      s/ov/un/id into the result register and go to RESP.
//    - RESP: o_rsp_valid=1 and result fields are held stable until
//      i_rsp_ready=1. On that handshake, if any i_req_valid is set, grant in
//      the same cycle and go to EXEC; otherwise go to IDLE.
//  - o_req_ready is 0 in EXEC, and 0 in RESP while i_rsp_ready=0.
//  - Latency: request accepted in cycle N gives o_rsp_valid in cycle N+2.
//  - Peak throughput: 1 op per 2 cycles.
//  - Requester rules: i_req_* must stay stable while valid and not ready.
//    A requester may drop valid before it is granted (no transfer occurs).
//  - Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
//  - Response backpressure: RESP holds with no limit; no new op is accepted
//    while holding.
//  - Reset mid-operation: the in-flight op is discarded, no response is
//    produced, and the FSM returns to IDLE with ptr=0.
//  - Special values (inf/NaN/zero) are passed through exactly as FPU_unit
//    produces them; no re-encoding.
// CONFIGURATION
//  FPU_SCHED_STATS_EN defined:
//  - Adds output o_ov_cnt[15:0]: counts responses handshaked with o_rsp_ov=1.
//  - Adds output o_un_cnt[15:0]: counts responses handshaked with o_rsp_un=1.
//  - Counting happens on the RESP handshake cycle only.
//  - Both counters saturate at 16'hFFFF and reset to 0.
//  FPU_SCHED_STATS_EN undefined: these ports and counters do not exist.
// STRUCTURE
//  Package fpu_sched_pkg:
//  - sched_state_t enum {IDLE, EXEC, RESP}
//  - FP32_W=32 and FP32_POS_INF=32'h7F800000
//  - typedef fpu_op_t struct {add_sub, a, b, id}
//  Sub-modules:
//  - fpu_rr_arbiter (combinational: request vector + pointer -> one-hot
//    grant + encoded id)
//  - FPU_unit, instantiated once
// TESTING
//  1. Req0 alone: add 3F800000 + 40000000 -> after 2 cycles rsp id=0,
//     s=40400000, ov=0, un=0.
//  2. Sub: A=40400000, B=3F800000, add_sub=1 -> s=40000000.
//  3. All 4 valid and held continuously -> grant order 0,1,2,3,0.
//     Each op is accepted 2 cycles after the previous one while i_rsp_ready=1.
//  4. i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_* stable, o_req_ready=0
//     throughout; release -> next grant taken in the same cycle.
//  5. Overflow: 7F7FFFFF + 7F7FFFFF -> s=7F800000, ov=1.
//     With FPU_SCHED_STATS_EN: o_ov_cnt increments by 1.
//  6. i_rst=1 during EXEC -> no response, o_busy=0 next cycle.
//     The next request from req2 is granted first (ptr=0, req0/req1 idle).

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg
//  Shared types and constants for the round-robin FPU scheduler slice.
//  - sched_state_t : scheduler FSM states
//  - fpu_op_t      : registered operation (op select, operands, requester tag)
//  - lzc27         : leading-zero count used by FPU_unit normalisation
package fpu_sched_pkg;

    localparam int          FP32_W       = 32;
    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

    // The tag field is sized for the largest supported NUM_REQ (8) so the
    // struct can live in the package; the top truncates it to ID_W.
    localparam int          ID_MAX_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic                add_sub;
        logic [FP32_W-1:0]   a;
        logic [FP32_W-1:0]   b;
        logic [ID_MAX_W-1:0] id;
    } fpu_op_t;

    // Returns 27 for an all-zero input; ascending scan so the highest set bit wins.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/FPU_unit.sv
// FPU_unit
//  Combinational FP32 adder/subtractor, round-to-nearest-even.
//  Subnormal inputs are treated as zero and subnormal results flush to zero.
//  Ports:
//    add_sub  in  1   0 = a+b, 1 = a-b (only when NUM_OP > 0)
//    a, b     in  32  FP32 operands
//    s        out 32  FP32 result
//    ov       out 1   result overflowed to infinity
//    un       out 1   non-zero result too small, flushed to zero
//  Parameter NUM_OP: number of operations beyond addition (0 = add only).
module FPU_unit
    import fpu_sched_pkg::*;
#(
    parameter int NUM_OP = 1
)(
    input  logic        add_sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s,
    output logic        ov,
    output logic        un
);

    logic              eff_sub, sign_b, sub_mag;
    logic              a_nan, b_nan, a_inf, b_inf, swap;
    logic              big_sign;
    logic [7:0]        big_exp, sml_exp, shift;
    logic [22:0]       big_frac, sml_frac;
    logic [26:0]       big_man, sml_man, aligned, norm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] exp_r;
    logic              rnd_up, frac_carry;
    logic [22:0]       frac_r;

    // Mantissas carry 3 extra low bits (guard, round, sticky) through
    // alignment and normalisation so rounding sees every discarded bit.
    always_comb begin
        s       = '0;
        ov      = 1'b0;
        un      = 1'b0;
        lz      = '0;
        eff_sub = add_sub & (NUM_OP > 0);
        sign_b  = b[31] ^ eff_sub;
        sub_mag = a[31] ^ sign_b;
        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

        swap     = b[30:0] > a[30:0];
        big_sign = swap ? sign_b   : a[31];
        big_exp  = swap ? b[30:23] : a[30:23];
        big_frac = swap ? b[22:0]  : a[22:0];
        sml_exp  = swap ? a[30:23] : b[30:23];
        sml_frac = swap ? a[22:0]  : b[22:0];

        big_man = (big_exp != 8'd0) ? {1'b1, big_frac, 3'b000} : '0;
        sml_man = (sml_exp != 8'd0) ? {1'b1, sml_frac, 3'b000} : '0;
        shift   = big_exp - sml_exp;

        if (shift >= 8'd27) begin
            aligned = {26'd0, |sml_man};
        end else begin
            aligned = (sml_man >> shift) | {26'd0, |(sml_man & ~({27{1'b1}} << shift))};
        end

        sum = sub_mag ? ({1'b0, big_man} - {1'b0, aligned})
                      : ({1'b0, big_man} + {1'b0, aligned});

        exp_r = $signed({2'b00, big_exp});
        if (sum[27]) begin
            norm  = sum[27:1] | {26'd0, sum[0]};
            exp_r = exp_r + 10'sd1;
        end else begin
            lz    = lzc27(sum[26:0]);
            norm  = sum[26:0] << lz;
            exp_r = exp_r - $signed({5'b00000, lz});
        end

        rnd_up     = norm[2] & (norm[1] | norm[0] | norm[3]);
        frac_carry = (&norm[25:3]) & rnd_up;
        frac_r     = norm[25:3] + 23'(rnd_up);
        if (frac_carry) begin
            exp_r = exp_r + 10'sd1;
        end

        // After normalisation bit 26 is set for every non-zero sum.
        if (a_nan || b_nan || (a_inf && b_inf && sub_mag)) begin
            s = FP32_QNAN;
        end else if (a_inf) begin
            s = a;
        end else if (b_inf) begin
            s = {sign_b, b[30:0]};
        end else if (!norm[26]) begin
            s = {sub_mag ? 1'b0 : big_sign, 31'd0};
        end else if (exp_r >= 10'sd255) begin
            s  = {big_sign, FP32_POS_INF[30:0]};
            ov = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            s  = {big_sign, 31'd0};
            un = 1'b1;
        end else begin
            s = {big_sign, exp_r[7:0], frac_r};
        end
    end

endmodule

// File: rtl/fpu_rr_scheduler_arbiter.sv
// fpu_rr_arbiter
//  Combinational round-robin arbiter: picks the first set request bit at or
//  after the pointer, wrapping at NUM_REQ.
//  Ports:
//    req    in   NUM_REQ   request vector
//    ptr    in   ID_MAX_W  highest-priority index (0..NUM_REQ-1)
//    grant  out  NUM_REQ   one-hot grant (all zero when no request)
//    id     out  ID_MAX_W  index of the granted requester
module fpu_rr_arbiter
    import fpu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_MAX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_MAX_W-1:0] id
);

    int   idx;
    logic found;

    // Inner loop compares against a constant k so every select is static.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && (k == idx) && req[k]) begin
                    grant[k] = 1'b1;
                    id       = ID_MAX_W'(k);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// fpu_rr_scheduler
//  Shares one combinational FPU_unit between NUM_REQ requesters using
//  round-robin arbitration, registered operands/results and a single tagged
//  response channel with backpressure.
//  Ports:
//    i_clk, i_rst             clock, synchronous active-high reset
//    i_req_valid/o_req_ready  per-requester handshake (ready is one-hot)
//    i_req_add_sub            per requester: 0 = A+B, 1 = A-B
//    i_req_a, i_req_b         packed operands, requester k at [32k+31:32k]
//    o_rsp_valid/i_rsp_ready  response handshake
//    o_rsp_id/s/ov/un         requester tag, FP32 result, overflow, underflow
//    o_busy                   FSM not in IDLE
//  Optional (macro FPU_SCHED_STATS_EN):
//    o_ov_cnt, o_un_cnt       saturating counts of handshaked ov/un responses
module fpu_rr_scheduler
    import fpu_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int NUM_OP  = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
)(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ-1:0]        i_req_add_sub,
    input  logic [NUM_REQ*FP32_W-1:0] i_req_a,
    input  logic [NUM_REQ*FP32_W-1:0] i_req_b,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [FP32_W-1:0]         o_rsp_s,
    output logic                      o_rsp_ov,
    output logic                      o_rsp_un,
    output logic                      o_busy
`ifdef FPU_SCHED_STATS_EN
    ,
    output logic [15:0]               o_ov_cnt,
    output logic [15:0]               o_un_cnt
`endif
);

    sched_state_t          state_q, state_d;
    fpu_op_t               op_q, op_d;
    logic [ID_MAX_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0]    arb_grant;
    logic [ID_MAX_W-1:0]   arb_id;
    logic                  op_load, rsp_load, rsp_fire;
    logic [FP32_W-1:0]     fpu_s;
    logic                  fpu_ov, fpu_un;

    fpu_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .req   (i_req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .id    (arb_id)
    );

    FPU_unit #(
        .NUM_OP (NUM_OP)
    ) u_fpu (
        .add_sub (op_q.add_sub),
        .a       (op_q.a),
        .b       (op_q.b),
        .s       (fpu_s),
        .ov      (fpu_ov),
        .un      (fpu_un)
    );

    // Mux the granted requester's fields into the operand register input.
    always_comb begin
        op_d    = '0;
        op_d.id = arb_id;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_grant[k]) begin
                op_d.add_sub = i_req_add_sub[k];
                op_d.a       = i_req_a[FP32_W*k +: FP32_W];
                op_d.b       = i_req_b[FP32_W*k +: FP32_W];
            end
        end
    end

    // Ready is only driven from IDLE, or from RESP on the response handshake
    // so back-to-back ops reach one op per two cycles. Reset forces ready low
    // so no transfer is reported while the FSM is being cleared.
    always_comb begin
        state_d     = state_q;
        o_req_ready = '0;
        op_load     = 1'b0;
        rsp_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|arb_grant) begin
                    o_req_ready = arb_grant;
                    op_load     = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                rsp_load = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    if (|arb_grant) begin
                        o_req_ready = arb_grant;
                        op_load     = 1'b1;
                        state_d     = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_rst) begin
            o_req_ready = '0;
            op_load     = 1'b0;
            rsp_load    = 1'b0;
            state_d     = IDLE;
        end
    end

    // The pointer advances while the accepted op executes; nothing arbitrates
    // during EXEC, so this matches advancing it at the transfer itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            op_q     <= '0;
            o_rsp_id <= '0;
            o_rsp_s  <= '0;
            o_rsp_ov <= 1'b0;
            o_rsp_un <= 1'b0;
        end else begin
            state_q <= state_d;
            if (op_load) begin
                op_q <= op_d;
            end
            if (rsp_load) begin
                o_rsp_id <= op_q.id[ID_W-1:0];
                o_rsp_s  <= fpu_s;
                o_rsp_ov <= fpu_ov;
                o_rsp_un <= fpu_un;
                ptr_q    <= (op_q.id == ID_MAX_W'(NUM_REQ - 1)) ? '0
                                                                 : op_q.id + ID_MAX_W'(1);
            end
        end
    end

    assign o_rsp_valid = (state_q == RESP);
    assign o_busy      = (state_q != IDLE);
    assign rsp_fire    = o_rsp_valid & i_rsp_ready;

`ifdef FPU_SCHED_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ov_cnt <= '0;
            o_un_cnt <= '0;
        end else if (rsp_fire) begin
            if (o_rsp_ov && (o_ov_cnt != 16'hFFFF)) begin
                o_ov_cnt <= o_ov_cnt + 16'd1;
            end
            if (o_rsp_un && (o_un_cnt != 16'hFFFF)) begin
                o_un_cnt <= o_un_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_rsp_fire;
    assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// tb_fpu_rr_scheduler
//  Directed self-checking bench for fpu_rr_scheduler (NUM_REQ=4).
//  Optional stats ports are connected when FPU_SCHED_STATS_EN is defined.
module tb_fpu_rr_scheduler;

    localparam int NUM_REQ = 4;

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic [NUM_REQ-1:0]      i_req_valid;
    logic [NUM_REQ-1:0]      o_req_ready;
    logic [NUM_REQ-1:0]      i_req_add_sub;
    logic [NUM_REQ*32-1:0]   i_req_a;
    logic [NUM_REQ*32-1:0]   i_req_b;
    logic                    o_rsp_valid;
    logic                    i_rsp_ready;
    logic [1:0]              o_rsp_id;
    logic [31:0]             o_rsp_s;
    logic                    o_rsp_ov;
    logic                    o_rsp_un;
    logic                    o_busy;
`ifdef FPU_SCHED_STATS_EN
    logic [15:0]             o_ov_cnt;
    logic [15:0]             o_un_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int expOvCnt = 0;
    int expUnCnt = 0;

    fpu_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .NUM_OP  (1)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_add_sub (i_req_add_sub),
        .i_req_a       (i_req_a),
        .i_req_b       (i_req_b),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_id      (o_rsp_id),
        .o_rsp_s       (o_rsp_s),
        .o_rsp_ov      (o_rsp_ov),
        .o_rsp_un      (o_rsp_un),
        .o_busy        (o_busy)
`ifdef FPU_SCHED_STATS_EN
        ,
        .o_ov_cnt      (o_ov_cnt),
        .o_un_cnt      (o_un_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required finish before 200000");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic applyStimulus(input int k, input logic addSub, input logic [31:0] a, input logic [31:0] b);
        i_req_valid[k]       = 1'b1;
        i_req_add_sub[k]     = addSub;
        i_req_a[32*k +: 32]  = a;
        i_req_b[32*k +: 32]  = b;
    endtask

    task automatic resetDut();
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_rsp_ready = 1'b1;
        tick();
        tick();
        i_rst    = 1'b0;
        expOvCnt = 0;
        expUnCnt = 0;
    endtask

    // One isolated op: grant, EXEC, RESP with expected fields, handshake.
    task automatic runSingle(input string tag, input int k, input logic addSub,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expS, input logic expOv, input logic expUn);
        applyStimulus(k, addSub, a, b);
        #1;
        checkOutput({tag, "_ready"}, 32'(o_req_ready), 32'(1 << k));
        tick();
        i_req_valid = '0;
        checkOutput({tag, "_exec_busy"}, 32'(o_busy), 32'd1);
        checkOutput({tag, "_exec_valid"}, 32'(o_rsp_valid), 32'd0);
        tick();
        checkOutput({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        checkOutput({tag, "_rsp_id"}, 32'(o_rsp_id), 32'(k));
        checkOutput({tag, "_rsp_s"}, o_rsp_s, expS);
        checkOutput({tag, "_rsp_ov"}, 32'(o_rsp_ov), 32'(expOv));
        checkOutput({tag, "_rsp_un"}, 32'(o_rsp_un), 32'(expUn));
        if (expOv) expOvCnt++;
        if (expUn) expUnCnt++;
        tick();
        checkOutput({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
`ifdef FPU_SCHED_STATS_EN
        checkOutput({tag, "_ov_cnt"}, 32'(o_ov_cnt), 32'(expOvCnt));
        checkOutput({tag, "_un_cnt"}, 32'(o_un_cnt), 32'(expUnCnt));
`endif
    endtask

    logic [31:0] fairExp [4] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
    logic [31:0] fairA   [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

    initial begin
        i_rst         = 1'b1;
        i_req_valid   = '0;
        i_req_add_sub = '0;
        i_req_a       = '0;
        i_req_b       = '0;
        i_rsp_ready   = 1'b1;
        applyStimulus(0, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
        tick();
        tick();
        checkOutput("reset_ready", 32'(o_req_ready), 32'd0);
        checkOutput("reset_busy", 32'(o_busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        checkOutput("reset_rsp_s", o_rsp_s, 32'd0);
        checkOutput("reset_rsp_id", 32'(o_rsp_id), 32'd0);
        checkOutput("reset_rsp_flags", {30'd0, o_rsp_ov, o_rsp_un}, 32'd0);
`ifdef FPU_SCHED_STATS_EN
        checkOutput("reset_ov_cnt", 32'(o_ov_cnt), 32'd0);
`endif
        i_rst       = 1'b0;
        i_req_valid = '0;

        runSingle("add_1p2", 0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        runSingle("sub_3m1", 1, 1'b1, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
        runSingle("ovf_max", 3, 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0);
        runSingle("unf_tiny", 2, 1'b1, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1);
        runSingle("cancel", 0, 1'b0, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0);

        // All four held valid: grants 0,1,2,3,0 every second cycle.
        resetDut();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k, 1'b0, fairA[k], 32'h3F80_0000);
        end
        #1;
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("rr_grant%0d", n), 32'(o_req_ready), 32'(1 << (n % 4)));
            tick();
            checkOutput($sformatf("rr_exec_ready%0d", n), 32'(o_req_ready), 32'd0);
            tick();
            #1;
            checkOutput($sformatf("rr_rsp_valid%0d", n), 32'(o_rsp_valid), 32'd1);
            checkOutput($sformatf("rr_rsp_id%0d", n), 32'(o_rsp_id), 32'(n % 4));
            checkOutput($sformatf("rr_rsp_s%0d", n), o_rsp_s, fairExp[n % 4]);
        end

        // Response backpressure for 5 cycles, then same-cycle grant on release.
        resetDut();
        i_rsp_ready = 1'b0;
        applyStimulus(0, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
        applyStimulus(1, 1'b0, 32'h4000_0000, 32'h3F80_0000);
        #1;
        checkOutput("bp_grant0", 32'(o_req_ready), 32'd1);
        tick();
        tick();
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("bp_hold_valid%0d", n), 32'(o_rsp_valid), 32'd1);
            checkOutput($sformatf("bp_hold_id%0d", n), 32'(o_rsp_id), 32'd0);
            checkOutput($sformatf("bp_hold_s%0d", n), o_rsp_s, 32'h4000_0000);
            checkOutput($sformatf("bp_hold_ready%0d", n), 32'(o_req_ready), 32'd0);
            tick();
        end
        i_rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_grant", 32'(o_req_ready), 32'd2);
        tick();
        i_req_valid = '0;
        checkOutput("bp_exec_valid", 32'(o_rsp_valid), 32'd0);
        tick();
        checkOutput("bp_rsp_id1", 32'(o_rsp_id), 32'd1);
        checkOutput("bp_rsp_s1", o_rsp_s, 32'h4040_0000);
        tick();

        // Reset during EXEC: op discarded, pointer back to 0.
        resetDut();
        applyStimulus(2, 1'b0, 32'h4040_0000, 32'h3F80_0000);
        #1;
        checkOutput("rst_grant2", 32'(o_req_ready), 32'd4);
        tick();
        applyStimulus(3, 1'b0, 32'h4080_0000, 32'h3F80_0000);
        i_rst = 1'b1;
        #1;
        checkOutput("rst_exec_busy", 32'(o_busy), 32'd1);
        tick();
        i_rst = 1'b0;
        #1;
        checkOutput("rst_after_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_after_valid", 32'(o_rsp_valid), 32'd0);
        checkOutput("rst_after_grant", 32'(o_req_ready), 32'd4);
        tick();
        i_req_valid = '0;
        checkOutput("rst_exec2_valid", 32'(o_rsp_valid), 32'd0);
        tick();
        checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 32'd1);
        checkOutput("rst_rsp_id", 32'(o_rsp_id), 32'd2);
        checkOutput("rst_rsp_s", o_rsp_s, 32'h4080_0000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
